// File: rtl/mix_bus_accumulator_if.sv
// Mix-bus accumulator request/RAM/result signals.
// The testbench drives the master side; the accumulator connects to the slave side.
interface mix_bus_accumulator_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] ch_addr;
  logic [23:0]       sample_in;
  logic [17:0]       gain_in;
  logic              busy;
  logic              acc_valid;
  logic [35:0]       acc_out;

  modport master (
    output start, sample_in, gain_in,
    input  ch_addr, busy, acc_valid, acc_out
  );

  modport slave (
    input  start, sample_in, gain_in,
    output ch_addr, busy, acc_valid, acc_out
  );
endinterface

// File: rtl/mix_bus_accumulator.sv
// Sequential multiply-accumulate over NUM_CHANNELS sample*gain pairs read from a
// 1-cycle-latency channel RAM; produces a Q7.29 bus sum per start pulse.
module mix_bus_accumulator #(
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned ADDR_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mix_bus_accumulator_if.slave  bus
);

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned GAIN_W   = 18;
  localparam int unsigned PROD_W   = SAMPLE_W + GAIN_W;
  localparam int unsigned ACC_W    = 36;
  localparam int unsigned SHIFT    = 10;
  localparam int unsigned TERM_W   = PROD_W - SHIFT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DRAIN
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          ch_addr_q, ch_addr_d;
  logic                       busy_q, busy_d;
  logic                       acc_valid_q, acc_valid_d;
  logic                       rd_valid_q, rd_valid_d;
  logic                       prod_valid_q, prod_valid_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [ACC_W-1:0]           acc_out_q, acc_out_d;

  logic signed [PROD_W-1:0]   sample_ext_c;
  logic signed [PROD_W-1:0]   gain_ext_c;
  logic [ACC_W-1:0]           term_c;
  logic [ACC_W-1:0]           acc_sum_c;

  // Q3.39 product floored to Q3.29 and sign-extended to the accumulator width.
  assign sample_ext_c = {{(PROD_W - SAMPLE_W){bus.sample_in[SAMPLE_W-1]}}, bus.sample_in};
  assign gain_ext_c   = {{(PROD_W - GAIN_W){bus.gain_in[GAIN_W-1]}}, bus.gain_in};
  assign term_c       = {{(ACC_W - TERM_W){prod_q[PROD_W-1]}}, prod_q[PROD_W-1:SHIFT]};
  assign acc_sum_c    = prod_valid_q ? (acc_q + term_c) : acc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ch_addr_q    <= '0;
      busy_q       <= 1'b0;
      acc_valid_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      prod_valid_q <= 1'b0;
      prod_q       <= '0;
      acc_q        <= '0;
      acc_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      ch_addr_q    <= ch_addr_d;
      busy_q       <= busy_d;
      acc_valid_q  <= acc_valid_d;
      rd_valid_q   <= rd_valid_d;
      prod_valid_q <= prod_valid_d;
      prod_q       <= prod_d;
      acc_q        <= acc_d;
      acc_out_q    <= acc_out_d;
    end
  end

  // Next state: RAM data for an ADDR cycle arrives one cycle later, its product
  // is registered on that edge and accumulated on the following one.
  always_comb begin
    state_d      = state_q;
    ch_addr_d    = ch_addr_q;
    busy_d       = busy_q;
    acc_valid_d  = 1'b0;
    rd_valid_d   = (state_q == ADDR);
    prod_valid_d = rd_valid_q;
    prod_d       = rd_valid_q ? (sample_ext_c * gain_ext_c) : prod_q;
    acc_d        = acc_sum_c;
    acc_out_d    = acc_out_q;

    unique case (state_q)
      IDLE: begin
        ch_addr_d = '0;
        if (bus.start) begin
          state_d = ADDR;
          busy_d  = 1'b1;
          acc_d   = '0;
        end
      end
      ADDR: begin
        if (ch_addr_q == LAST_ADDR) begin
          state_d   = DRAIN;
          ch_addr_d = '0;
        end else begin
          ch_addr_d = ch_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // Last product sits in prod_q once no read is outstanding.
        if (!rd_valid_q) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          acc_valid_d = 1'b1;
          acc_out_d   = acc_sum_c;
        end
      end
      default: begin
        state_d   = IDLE;
        ch_addr_d = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  assign bus.ch_addr   = ch_addr_q;
  assign bus.busy      = busy_q;
  assign bus.acc_valid = acc_valid_q;
  assign bus.acc_out   = acc_out_q;

endmodule
